// File: rtl/noc_output_arbiter.sv
// noc_output_arbiter: per-output round-robin switch allocator with wormhole packet lock and credit tracking.
// Optional macro NOC_ARB_ERR_EN adds a sticky protocol-error output err_o.
`timescale 1ns/1ps
`default_nettype none

module noc_output_arbiter #(
    parameter int IN_PORTS  = 5,
    parameter int BUF_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [IN_PORTS-1:0]           req_i,
    input  logic [2*IN_PORTS-1:0]         label_i,
    input  logic                          credit_i,
    output logic [IN_PORTS-1:0]           grant_o,
    output logic                          valid_o,
    output logic [$clog2(IN_PORTS)-1:0]   sel_o,
    output logic [$clog2(BUF_DEPTH+1)-1:0] credits_o,
    output logic                          locked_o
`ifdef NOC_ARB_ERR_EN
    ,
    output logic                          err_o
`endif
);

    localparam int c_SEL_W = $clog2(IN_PORTS);
    localparam int c_CNT_W = $clog2(BUF_DEPTH+1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_SEL_W-1:0] c_LAST = c_SEL_W'(IN_PORTS-1);
    localparam logic [1:0] c_HEAD = 2'd0;
    localparam logic [1:0] c_HT   = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_SEL_W-1:0]   r_owner;
    logic [c_SEL_W-1:0]   r_ptr;
    logic [c_SEL_W-1:0]   r_sel;
    logic [c_CNT_W-1:0]   r_credits;

    logic [IN_PORTS-1:0]  w_head;
    logic [IN_PORTS-1:0]  w_lab_lsb;
    logic [IN_PORTS-1:0]  w_elig;
    logic [IN_PORTS-1:0]  w_viol;
    logic                 w_found;
    logic [c_SEL_W-1:0]   w_win;
    logic [c_SEL_W-1:0]   w_idx;
    logic                 w_win_lsb;
    logic                 w_go;
    logic [c_SEL_W-1:0]   w_ptr_next;
    logic [c_CNT_W-1:0]   w_cred_next;

    generate
        for (genvar gi = 0; gi < IN_PORTS; gi++) begin : g_port
            logic [1:0] w_lab;
            logic       w_owner_hit;
            assign w_lab          = label_i[2*gi +: 2];
            assign w_head[gi]     = (w_lab == c_HEAD) || (w_lab == c_HT);
            assign w_lab_lsb[gi]  = w_lab[0];
            assign w_owner_hit    = (r_owner == c_SEL_W'(gi));
            assign w_elig[gi]     = req_i[gi] && ((r_state == ST_IDLE) ? w_head[gi]
                                                                       : (w_owner_hit && !w_head[gi]));
            assign w_viol[gi]     = req_i[gi] && ((r_state == ST_IDLE) ? !w_head[gi]
                                                                       : (w_owner_hit && w_head[gi]));
        end
    endgenerate

    // Scan eligible inputs starting at the round-robin pointer, wrapping modulo IN_PORTS.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_win_lsb = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < IN_PORTS; k++) begin
            w_idx = c_SEL_W'((int'(r_ptr) + k) % IN_PORTS);
            if (!w_found && w_elig[w_idx]) begin
                w_found   = 1'b1;
                w_win     = w_idx;
                w_win_lsb = w_lab_lsb[w_idx];
            end
        end
    end

    assign w_go       = w_found && (r_credits != '0) && !rst;
    assign grant_o    = w_go ? (IN_PORTS'(1) << w_win) : '0;
    assign valid_o    = w_go;
    assign sel_o      = w_go ? w_win : r_sel;
    assign credits_o  = r_credits;
    assign locked_o   = (r_state == ST_LOCKED);
    assign w_ptr_next = (w_win == c_LAST) ? '0 : (w_win + 1'b1);

    always_comb begin
        w_cred_next = r_credits;
        if (w_go && !credit_i) begin
            w_cred_next = r_credits - 1'b1;
        end else if (!w_go && credit_i && (r_credits != c_FULL)) begin
            w_cred_next = r_credits + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_credits <= c_FULL;
        end else begin
            r_credits <= w_cred_next;
            if (w_go) begin
                r_sel <= w_win;
                // Label bit 0 low means HEAD when idle (open a packet) or TAIL when locked (close it).
                if (r_state == ST_IDLE) begin
                    r_ptr <= w_ptr_next;
                    if (!w_win_lsb) begin
                        r_state <= ST_LOCKED;
                        r_owner <= w_win;
                    end
                end else if (!w_win_lsb) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

`ifdef NOC_ARB_ERR_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((|w_viol) || (credit_i && (r_credits == c_FULL) && !w_go)) begin
            r_err <= 1'b1;
        end
    end
    assign err_o = r_err;
`else
    logic w_unused;
    assign w_unused = |w_viol;
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_output_arbiter.sv
// tb_noc_output_arbiter: scoreboard bench for noc_output_arbiter (IN_PORTS=5, BUF_DEPTH=8).
// Checks err_o as well when built with NOC_ARB_ERR_EN.
`timescale 1ns/1ps
`default_nettype none

module tb_noc_output_arbiter;

    localparam logic [1:0] H  = 2'd0;
    localparam logic [1:0] B  = 2'd1;
    localparam logic [1:0] T  = 2'd2;
    localparam logic [1:0] HT = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req_i;
    logic [9:0] label_i;
    logic       credit_i;
    logic [4:0] grant_o;
    logic       valid_o;
    logic [2:0] sel_o;
    logic [3:0] credits_o;
    logic       locked_o;
`ifdef NOC_ARB_ERR_EN
    logic       err_o;
`endif

    noc_output_arbiter #(.IN_PORTS(5), .BUF_DEPTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .label_i   (label_i),
        .credit_i  (credit_i),
        .grant_o   (grant_o),
        .valid_o   (valid_o),
        .sel_o     (sel_o),
        .credits_o (credits_o),
        .locked_o  (locked_o)
`ifdef NOC_ARB_ERR_EN
        ,
        .err_o     (err_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [4:0] g;
        logic [2:0] s;
        logic [3:0] c;
        logic       l;
        logic       e;
    } exp_t;

    exp_t sb[$];
    exp_t r_x;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] lb1(input int p, input logic [1:0] l);
        logic [9:0] v;
        v = '0;
        v[2*p +: 2] = l;
        return v;
    endfunction

    // Expectation is queued when the cycle's stimulus is applied and consumed mid-cycle.
    task automatic drive(input logic [4:0] rq, input logic [9:0] lb, input logic cr, input string tag,
                         input logic [4:0] g, input logic [2:0] s, input logic [3:0] c,
                         input logic l, input logic e);
        exp_t x;
        req_i = rq;
        label_i = lb;
        credit_i = cr;
        x.tag = tag; x.g = g; x.s = s; x.c = c; x.l = l; x.e = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            r_x = sb.pop_front();
            chk({r_x.tag, ".grant"}, 32'(grant_o), 32'(r_x.g));
            chk({r_x.tag, ".valid"}, 32'(valid_o), 32'(|r_x.g));
            chk({r_x.tag, ".sel"}, 32'(sel_o), 32'(r_x.s));
            chk({r_x.tag, ".credits"}, 32'(credits_o), 32'(r_x.c));
            chk({r_x.tag, ".locked"}, 32'(locked_o), 32'(r_x.l));
`ifdef NOC_ARB_ERR_EN
            chk({r_x.tag, ".err"}, 32'(err_o), 32'(r_x.e));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_i = '0;
        label_i = '0;
        credit_i = 1'b0;
        @(posedge clk);
        #1;
        drive(5'b11111, {5{HT}}, 1'b0, "rst", 5'b0, 3'd0, 4'd8, 1'b0, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 10; k++)
            drive(5'b11111, {5{HT}}, 1'b1, "rr", 5'(1 << (k % 5)), 3'(k % 5), 4'd8, 1'b0, 1'b0);

        // Move the pointer past input 0 so input 2's HEAD wins first.
        drive(5'b00001, {5{HT}}, 1'b1, "prep", 5'b00001, 3'd0, 4'd8, 1'b0, 1'b0);
        drive(5'b00101, lb1(2, H), 1'b1, "lk_head",  5'b00100, 3'd2, 4'd8, 1'b0, 1'b0);
        drive(5'b00101, lb1(2, B), 1'b1, "lk_body1", 5'b00100, 3'd2, 4'd8, 1'b1, 1'b0);
        drive(5'b00101, lb1(2, B), 1'b1, "lk_body2", 5'b00100, 3'd2, 4'd8, 1'b1, 1'b0);
        drive(5'b00101, lb1(2, T), 1'b1, "lk_tail",  5'b00100, 3'd2, 4'd8, 1'b1, 1'b0);
        drive(5'b00001, lb1(0, H), 1'b1, "lk_next",  5'b00001, 3'd0, 4'd8, 1'b0, 1'b0);
        drive(5'b00001, lb1(0, T), 1'b1, "lk_next_tail", 5'b00001, 3'd0, 4'd8, 1'b1, 1'b0);
        drive(5'b00000, 10'b0,     1'b0, "lk_idle",  5'b00000, 3'd0, 4'd8, 1'b0, 1'b0);

        for (int k = 0; k < 10; k++)
            drive(5'b00010, {5{HT}}, 1'b0, "ex", (k < 8) ? 5'b00010 : 5'b0, 3'd1,
                  (k < 8) ? 4'(8 - k) : 4'd0, 1'b0, 1'b0);
        drive(5'b00010, {5{HT}}, 1'b1, "ex_cr",  5'b00000, 3'd1, 4'd0, 1'b0, 1'b0);
        drive(5'b00010, {5{HT}}, 1'b0, "ex_one", 5'b00010, 3'd1, 4'd1, 1'b0, 1'b0);
        drive(5'b00010, {5{HT}}, 1'b0, "ex_dry", 5'b00000, 3'd1, 4'd0, 1'b0, 1'b0);

        drive(5'b10000, {5{HT}}, 1'b1, "nb_same", 5'b00000, 3'd1, 4'd0, 1'b0, 1'b0);
        drive(5'b10000, {5{HT}}, 1'b0, "nb_next", 5'b10000, 3'd4, 4'd1, 1'b0, 1'b0);
        drive(5'b00000, 10'b0,   1'b0, "nb_zero", 5'b00000, 3'd4, 4'd0, 1'b0, 1'b0);

        for (int k = 0; k < 8; k++)
            drive(5'b00000, 10'b0, 1'b1, "refill", 5'b00000, 3'd4, 4'(k), 1'b0, 1'b0);

        drive(5'b01000, lb1(3, H), 1'b1, "rm_head", 5'b01000, 3'd3, 4'd8, 1'b0, 1'b0);
        drive(5'b01000, lb1(3, B), 1'b1, "rm_body", 5'b01000, 3'd3, 4'd8, 1'b1, 1'b0);
        rst = 1'b1;
        drive(5'b01000, lb1(3, B), 1'b0, "rm_rst",  5'b00000, 3'd3, 4'd8, 1'b1, 1'b0);
        rst = 1'b0;
        drive(5'b00001, lb1(0, H), 1'b1, "rm_after", 5'b00001, 3'd0, 4'd8, 1'b0, 1'b0);
        drive(5'b00001, lb1(0, T), 1'b1, "rm_tail",  5'b00001, 3'd0, 4'd8, 1'b1, 1'b0);

        drive(5'b01000, lb1(3, B), 1'b0, "err_body", 5'b00000, 3'd0, 4'd8, 1'b0, 1'b0);
        drive(5'b00000, 10'b0,     1'b0, "err_set",  5'b00000, 3'd0, 4'd8, 1'b0, 1'b1);
        drive(5'b00000, 10'b0,     1'b1, "sat",      5'b00000, 3'd0, 4'd8, 1'b0, 1'b1);
        drive(5'b00000, 10'b0,     1'b0, "sat_hold", 5'b00000, 3'd0, 4'd8, 1'b0, 1'b1);

        rst = 1'b1;
        drive(5'b00000, 10'b0, 1'b0, "rst2",       5'b00000, 3'd0, 4'd8, 1'b0, 1'b1);
        rst = 1'b0;
        drive(5'b00000, 10'b0, 1'b0, "rst2_after", 5'b00000, 3'd0, 4'd8, 1'b0, 1'b0);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/noc_output_arbiter.md
# noc_output_arbiter

- Per-output-port switch allocator for the 6x6 wormhole mesh router; one instance per router output (LOCAL, NORTH, EAST, SOUTH, WEST).
- Shares one output among the 5 input ports with round-robin arbitration.
- Holds the output for one packet from HEAD to TAIL.
- Tracks downstream buffer credits and drives the crossbar select.

## Interface
- `IN_PORTS`, default 5: number of requesting input ports (matches `in_Port_Cnt`).
- `BUF_DEPTH`, default 8: downstream input-buffer depth in flits; initial credit count.
- `clk`  in  1  Router clock. Single clock domain.
- `rst`  in  1  Synchronous, active-high reset.
- `req_i`  in  IN_PORTS  `req_i[i]`=1: input i has a flit at its buffer head routed to this output.
- `label_i`  in  2*IN_PORTS  `flit_Data_Label` of input i's head flit, in bits [2i+1:2i] (HEAD=0, BODY=1, TAIL=2, HEADTAIL=3).
- `credit_i`  in  1  Downstream freed one buffer slot this cycle.
- `grant_o`  out  IN_PORTS  One-hot or zero. The granted input pops its flit this cycle.
- `valid_o`  out  1  A flit crosses the output this cycle (`|grant_o`).
- `sel_o`  out  $clog2(IN_PORTS)  Index of the granted input (crossbar mux select). Holds the last value when `valid_o`=0.
- `credits_o`  out  $clog2(BUF_DEPTH+1)  Current credit count.
- `locked_o`  out  1  Output is owned by an in-flight multi-flit packet.

## Operation
- State registers: `state` (IDLE/LOCKED), `owner` (input index), `ptr` (round-robin start index), `credits`.
- IDLE: eligible inputs have `req_i`=1 and a label of HEAD or HEADTAIL.
  - The winner is the first eligible input scanning from `ptr` upward, modulo IN_PORTS.
  - A grant is issued only if `credits`>0.
  - On a winning HEAD: go to LOCKED and set `owner`=winner.
  - On a winning HEADTAIL: stay in IDLE.
  - On any grant: `ptr`=winner+1, wrapping from IN_PORTS-1 to 0.
- LOCKED: only `owner` is eligible, and only with a BODY or TAIL label and `credits`>0.
  - On a granted TAIL: go to IDLE.
  - Requests from other inputs are not granted.
  - `ptr` is unchanged while LOCKED.
- Protocol violations:
  - BODY/TAIL from any input while IDLE: never granted.
  - HEAD/HEADTAIL from the owner while LOCKED: never granted.
- Credit update: `credits_next` = `credits` − `valid_o` + `credit_i`.
  - A simultaneous grant and credit return nets zero.
  - `credit_i` while `credits`=BUF_DEPTH and no grant: count saturates at BUF_DEPTH.
- `locked_o` = (`state`==LOCKED).

## Timing
- Grant path is combinational: `req_i`/`label_i` → `grant_o`/`valid_o`/`sel_o` in the same cycle, zero latency.
- `state`, `owner`, `ptr` and `credits` update on the `clk` rising edge.
- No credit bypass: a credit returned in cycle N is usable from cycle N+1. A grant in cycle N with `credits`=0 is forbidden.
- Maximum throughput is one flit per cycle while credits remain.
- A packet of length L holds the output for at least L cycles.
- A new packet may be granted in the cycle immediately after its predecessor's TAIL grant.
- While `rst`=1: `grant_o`=0, `valid_o`=0.
- Values after any cycle with `rst` high:
  - `sel_o`=0, `credits_o`=BUF_DEPTH, `locked_o`=0, `ptr`=0, `owner`=0.
  - `err_o`=0 when the `NOC_ARB_ERR_EN` port is present.
- Reset mid-packet drops the lock unconditionally. Upstream/downstream flush is the router's responsibility.

## Configuration
- Macro: `NOC_ARB_ERR_EN`.
- Defined: adds port `err_o  out  1`, a sticky protocol-error flag cleared only by `rst`. It is set on the next edge after any of:
  - BODY/TAIL requested while IDLE;
  - HEAD/HEADTAIL from the owner while LOCKED;
  - `credit_i` while `credits`=BUF_DEPTH and `valid_o`=0.
- Undefined: no `err_o` port and no error logic. Violations are silently ignored, never granted, and credits saturate as above.

## Test plan
- Round-robin fairness:
  - Stimulus: after reset, all 5 `req_i`=1 with HEADTAIL continuously; `credit_i`=`valid_o` each cycle.
  - Required: `sel_o` = 0,1,2,3,4,0,… on consecutive cycles, and `credits_o` stays 8.
- Packet lock:
  - Stimulus: input 2 sends HEAD, BODY, BODY, TAIL on consecutive cycles; input 0 holds HEAD throughout.
  - Required: input 0 is granted in the cycle after input 2's TAIL, and `locked_o`=1 for exactly 3 cycles.
- Credit exhaustion:
  - Stimulus: BUF_DEPTH=8, `credit_i`=0, input 1 offers 10 HEADTAIL flits.
  - Required: exactly 8 grants, then `valid_o`=0 and `credits_o`=0. One `credit_i` pulse yields exactly one grant, in the following cycle.
- No bypass:
  - Stimulus: `credits_o`=0, and `credit_i`=1 in the same cycle input 4 requests HEADTAIL.
  - Required: no grant that cycle; grant the next cycle; `credits_o` returns to 0.
- Reset mid-packet:
  - Stimulus: assert `rst` after input 3's HEAD plus one BODY.
  - Required: `grant_o`=0 during reset; next cycle `locked_o`=0 and `credits_o`=8; a HEAD from input 0 is then granted.
- Error flag (`NOC_ARB_ERR_EN` defined):
  - Stimulus: input 3 requests BODY while IDLE.
  - Required: no grant; `err_o`=1 from the next cycle and it stays 1 until `rst`.
